// File: rtl/counter_ctrl.sv
// counter_ctrl: sequencing controller for a reloadable timer/event counter
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   start        load reload_val and run
//   stop         halt counting and go idle (beats start)
//   mode         0 = timer (prescaled clk), 1 = event (evt rising edges)
//   auto_reload  1 = reload on overflow, 0 = one-shot
//   reload_val   load and reload value
//   prescale     timer divide ratio minus one, sampled live
//   evt          asynchronous event input
//   ack          clears tf and ovr
//   count        current count
//   running      high while in RUN
//   tf           sticky overflow flag
//   ovr          sticky overrun flag (overflow while tf already set)
//   tick         high when count advances at the next edge by counting
module counter_ctrl #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  mode,
    input  logic                  auto_reload,
    input  logic [WIDTH-1:0]      reload_val,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  evt,
    input  logic                  ack,
    output logic [WIDTH-1:0]      count,
    output logic                  running,
    output logic                  tf,
    output logic                  ovr,
    output logic                  tick
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state, state_nx;
    logic [WIDTH-1:0]        count_nx;
    logic [PRESCALE_W-1:0]   p, p_nx;
    logic                    s1, s2, s3;
    logic                    timer_hit, evt_edge, raw_tick, ovf;

    assign timer_hit = (p == prescale);
    // s1/s2 synchronise evt; s3 delays s2 so a held level counts once
    assign evt_edge  = s2 & ~s3;
    assign raw_tick  = (state == RUN) && (mode ? evt_edge : timer_hit);

    always_comb begin
        state_nx = state;
        count_nx = count;
        p_nx     = p;
        ovf      = 1'b0;
        tick     = 1'b0;
        case (state)
            IDLE: begin
                if (!stop && start) begin
                    count_nx = reload_val;
                    p_nx     = '0;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nx = IDLE;
                end else if (start) begin
                    count_nx = reload_val;
                    p_nx     = '0;
                end else begin
                    // prescaler free-runs in RUN so a mode switch keeps its phase
                    p_nx = timer_hit ? '0 : p + PRESCALE_W'(1);
                    if (raw_tick) begin
                        tick = rst_n;
                        if (count == '1) begin
                            ovf      = 1'b1;
                            count_nx = auto_reload ? reload_val : '0;
                            state_nx = auto_reload ? RUN : DONE;
                        end else begin
                            count_nx = count + WIDTH'(1);
                        end
                    end
                end
            end
            DONE: begin
                if (stop) begin
                    state_nx = IDLE;
                end else if (start) begin
                    count_nx = reload_val;
                    p_nx     = '0;
                    state_nx = RUN;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            p       <= '0;
            tf      <= 1'b0;
            ovr     <= 1'b0;
            running <= 1'b0;
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
        end else begin
            state   <= state_nx;
            count   <= count_nx;
            p       <= p_nx;
            // overflow beats ack for tf; ack always clears ovr
            tf      <= ack ? ovf : (tf | ovf);
            ovr     <= ack ? 1'b0 : (ovr | (ovf & tf));
            running <= (state_nx == RUN);
            s1      <= evt;
            s2      <= s1;
            s3      <= s2;
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: table-driven and directed checks of counter_ctrl
module tb_counter_ctrl;

    logic       clk, rst_n, start, stop, mode, auto_reload, evt, ack;
    logic [7:0] reload_val, count;
    logic [3:0] prescale;
    logic       running, tf, ovr, tick;

    int nvec = 0;
    int errs = 0;

    counter_ctrl #(.WIDTH(8), .PRESCALE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .auto_reload(auto_reload), .reload_val(reload_val), .prescale(prescale),
        .evt(evt), .ack(ack), .count(count), .running(running), .tf(tf),
        .ovr(ovr), .tick(tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // tk is tick before the edge; cnt/run/tf/ovr are registered values after it
    typedef struct {
        logic       rst_n, start, stop, mode, ar, ack;
        logic [7:0] rl;
        logic [3:0] ps;
        logic       evt, tk;
        logic [7:0] cnt;
        logic       run, tf, ovr;
    } vec_t;

    vec_t v[$];

    task automatic add(input logic r, s, p, m, a, k, input logic [7:0] rl,
                       input logic [3:0] ps, input logic e, tk,
                       input logic [7:0] c, input logic rn, t, o);
        v.push_back('{r, s, p, m, a, k, rl, ps, e, tk, c, rn, t, o});
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s #%0d: got %0h want %0h", nm, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 0; start = 0; stop = 0; mode = 0; auto_reload = 0;
        evt = 0; ack = 0; reload_val = 0; prescale = 0;
        // reset with start/evt asserted, then release
        add(0,1,0,0,0,0,8'hFC,1,1, 0,8'h00,0,0,0);
        add(0,1,0,0,0,0,8'hFC,1,1, 0,8'h00,0,0,0);
        add(1,0,0,0,0,0,8'hFC,1,0, 0,8'h00,0,0,0);
        add(1,0,0,0,0,0,8'hFC,1,0, 0,8'h00,0,0,0);
        // one-shot timer, prescale 1
        add(1,1,0,0,0,0,8'hFC,1,0, 0,8'hFC,1,0,0);
        add(1,0,0,0,0,0,8'hFC,1,0, 0,8'hFC,1,0,0);
        add(1,0,0,0,0,0,8'hFC,1,0, 1,8'hFD,1,0,0);
        add(1,0,0,0,0,0,8'hFC,1,0, 0,8'hFD,1,0,0);
        add(1,0,0,0,0,0,8'hFC,1,0, 1,8'hFE,1,0,0);
        add(1,0,0,0,0,0,8'hFC,1,0, 0,8'hFE,1,0,0);
        add(1,0,0,0,0,0,8'hFC,1,0, 1,8'hFF,1,0,0);
        add(1,0,0,0,0,0,8'hFC,1,0, 0,8'hFF,1,0,0);
        add(1,0,0,0,0,0,8'hFC,1,0, 1,8'h00,0,1,0);
        add(1,0,0,0,0,0,8'hFC,1,0, 0,8'h00,0,1,0);
        add(1,0,0,0,0,0,8'hFC,1,0, 0,8'h00,0,1,0);
        // auto-reload, prescale 0, overrun, ack, ack-vs-overflow
        add(1,0,0,0,1,1,8'hFE,0,0, 0,8'h00,0,0,0);
        add(1,1,0,0,1,0,8'hFE,0,0, 0,8'hFE,1,0,0);
        add(1,0,0,0,1,0,8'hFE,0,0, 1,8'hFF,1,0,0);
        add(1,0,0,0,1,0,8'hFE,0,0, 1,8'hFE,1,1,0);
        add(1,0,0,0,1,0,8'hFE,0,0, 1,8'hFF,1,1,0);
        add(1,0,0,0,1,0,8'hFE,0,0, 1,8'hFE,1,1,1);
        add(1,0,0,0,1,1,8'hFE,0,0, 1,8'hFF,1,0,0);
        add(1,0,0,0,1,0,8'hFE,0,0, 1,8'hFE,1,1,0);
        add(1,0,0,0,1,0,8'hFE,0,0, 1,8'hFF,1,1,0);
        add(1,0,0,0,1,1,8'hFE,0,0, 1,8'hFE,1,1,0);
        add(1,0,0,0,1,0,8'hFE,0,0, 1,8'hFF,1,1,0);
        add(1,0,0,0,1,0,8'hFE,0,0, 1,8'hFE,1,1,1);
        // start and stop together in RUN -> idle, count held
        add(1,1,1,0,1,0,8'hFE,0,0, 0,8'hFE,0,1,1);
        add(1,0,0,0,1,1,8'hFE,0,0, 0,8'hFE,0,0,0);
        // stop coincident with a tick at 0x10
        add(1,1,0,0,0,0,8'h10,0,0, 0,8'h10,1,0,0);
        add(1,0,1,0,0,0,8'h10,0,0, 0,8'h10,0,0,0);
        add(1,0,0,0,0,0,8'h10,0,0, 0,8'h10,0,0,0);

        for (int i = 0; i < v.size(); i++) begin
            rst_n = v[i].rst_n; start = v[i].start; stop = v[i].stop;
            mode = v[i].mode; auto_reload = v[i].ar; ack = v[i].ack;
            reload_val = v[i].rl; prescale = v[i].ps; evt = v[i].evt;
            #2;
            chk("tick", i, tick, v[i].tk);
            step();
            chk("count", i, count, v[i].cnt);
            chk("running", i, running, v[i].run);
            chk("tf", i, tf, v[i].tf);
            chk("ovr", i, ovr, v[i].ovr);
        end

        // event mode: four 3-high/3-low pulses
        rst_n = 1; ack = 0; stop = 0; mode = 1; auto_reload = 0;
        reload_val = 8'h00; evt = 0; start = 1;
        step();
        start = 0;
        chk("evt_start", 0, count, 8'h00);
        chk("evt_run", 0, running, 1);
        for (int k = 0; k < 4; k++) begin
            evt = 1;
            step();
            step();
            chk("evt_early", k, count, k);
            chk("evt_tick", k, tick, 1);
            step();
            chk("evt_inc", k, count, k + 1);
            evt = 0;
            repeat (3) step();
        end
        chk("evt_four", 0, count, 8'h04);
        // held level counts once
        evt = 1;
        repeat (10) step();
        evt = 0;
        repeat (3) step();
        chk("evt_level", 0, count, 8'h05);
        // pulses while idle are dropped
        stop = 1;
        step();
        stop = 0;
        chk("evt_idle", 0, running, 0);
        evt = 1;
        repeat (3) step();
        evt = 0;
        repeat (3) step();
        chk("evt_idle_hold", 0, count, 8'h05);
        start = 1;
        step();
        start = 0;
        repeat (5) step();
        chk("evt_restart", 0, count, 8'h00);
        chk("evt_restart_run", 0, running, 1);

        // reset mid-run at 0x80 with tf set
        mode = 0; auto_reload = 1; prescale = 0; reload_val = 8'hFF; start = 1;
        step();
        start = 0;
        chk("mr_load", 0, count, 8'hFF);
        reload_val = 8'h7F;
        step();
        chk("mr_reload", 0, count, 8'h7F);
        chk("mr_tf", 0, tf, 1);
        step();
        chk("mr_80", 0, count, 8'h80);
        rst_n = 0;
        #2;
        chk("mr_rst_tick", 0, tick, 0);
        step();
        chk("mr_rst_count", 0, count, 8'h00);
        chk("mr_rst_tf", 0, tf, 0);
        chk("mr_rst_run", 0, running, 0);
        rst_n = 1; reload_val = 8'h33; prescale = 2; start = 1;
        step();
        start = 0;
        chk("mr_restart", 0, count, 8'h33);
        chk("mr_restart_run", 0, running, 1);
        step();
        step();
        chk("mr_wait", 0, count, 8'h33);
        step();
        chk("mr_inc", 0, count, 8'h34);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
